// File: rtl/mdom_scdb_hdr_serializer_pkg.sv
// SCDB header serializer: shared field map, word counts and types.
// Offsets follow the packed 113-bit header bundle layout.
package mdom_scdb_hdr_serializer_pkg;

  localparam int BUNDLE_W = 113;

  localparam int EVT_LTC_LSB = 0;
  localparam int EVT_LTC_W = 49;
  localparam int START_LSB = 49;
  localparam int STOP_LSB = 61;
  localparam int ADDR_W = 12;
  localparam int TRIG_LSB = 73;
  localparam int TRIG_W = 2;
  localparam int CNST_BIT = 75;
  localparam int PRE_LSB = 76;
  localparam int PRE_W = 5;
  localparam int SYNC_BIT = 81;
  localparam int BSUM_LSB = 82;
  localparam int BSUM_W = 19;
  localparam int BLEN_LSB = 101;
  localparam int BLEN_W = 3;
  localparam int BVAL_BIT = 104;
  localparam int LCOIN_BIT = 105;
  localparam int PART_BIT = 106;
  localparam int CONT_BIT = 107;
  localparam int CHAN_LSB = 108;
  localparam int CHAN_W = 5;

  localparam logic [3:0] MAGIC_DEF = 4'hA;
  localparam int WORDS_FULL = 8;
  localparam int WORDS_SHORT = 6;
  localparam int IDX_W = 3;

  typedef struct packed {
    logic [CHAN_W-1:0] channel_idx;
    logic continued_wfm;
    logic partial_wfm;
    logic local_coinc;
    logic bsum_valid;
    logic [BLEN_W-1:0] bsum_len_sel;
    logic [BSUM_W-1:0] bsum;
    logic sync_rdy;
    logic [PRE_W-1:0] pre_conf;
    logic cnst_run;
    logic [TRIG_W-1:0] trig_src;
    logic [ADDR_W-1:0] stop_addr;
    logic [ADDR_W-1:0] start_addr;
    logic [EVT_LTC_W-1:0] evt_ltc;
  } hdr_t;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

endpackage

// File: rtl/mdom_scdb_hdr_serializer_if.sv
// Header-in / word-out handshake bundle for the SCDB serializer.
// slave is the serializer's view, master the producer/consumer side.
interface mdom_scdb_hdr_serializer_if;
  import mdom_scdb_hdr_serializer_pkg::*;

  logic [BUNDLE_W-1:0] hdr_bundle;
  logic hdr_valid;
  logic hdr_ready;
  logic [15:0] dout;
  logic dout_valid;
  logic dout_last;
  logic dout_ready;
  logic [15:0] hdr_cnt;

  modport slave (
    input hdr_bundle, hdr_valid, dout_ready,
    output hdr_ready, dout, dout_valid, dout_last, hdr_cnt
  );

  modport master (
    output hdr_bundle, hdr_valid, dout_ready,
    input hdr_ready, dout, dout_valid, dout_last, hdr_cnt
  );

endinterface

// File: rtl/mDOM_scdb_hdr_bundle_fan_out.sv
// Unpacks the flat header bundle into named fields.
// Pure wiring; exact inverse of the bundle packer.
module mDOM_scdb_hdr_bundle_fan_out
  import mdom_scdb_hdr_serializer_pkg::*;
(
  input  logic [BUNDLE_W-1:0] i_bundle,
  output hdr_t                o_hdr
);

  always_comb begin
    o_hdr.evt_ltc = i_bundle[EVT_LTC_LSB +: EVT_LTC_W];
    o_hdr.start_addr = i_bundle[START_LSB +: ADDR_W];
    o_hdr.stop_addr = i_bundle[STOP_LSB +: ADDR_W];
    o_hdr.trig_src = i_bundle[TRIG_LSB +: TRIG_W];
    o_hdr.cnst_run = i_bundle[CNST_BIT];
    o_hdr.pre_conf = i_bundle[PRE_LSB +: PRE_W];
    o_hdr.sync_rdy = i_bundle[SYNC_BIT];
    o_hdr.bsum = i_bundle[BSUM_LSB +: BSUM_W];
    o_hdr.bsum_len_sel = i_bundle[BLEN_LSB +: BLEN_W];
    o_hdr.bsum_valid = i_bundle[BVAL_BIT];
    o_hdr.local_coinc = i_bundle[LCOIN_BIT];
    o_hdr.partial_wfm = i_bundle[PART_BIT];
    o_hdr.continued_wfm = i_bundle[CONT_BIT];
    o_hdr.channel_idx = i_bundle[CHAN_LSB +: CHAN_W];
  end

endmodule

// File: rtl/mdom_scdb_hdr_serializer.sv
// Serializes one captured SCDB header bundle into 6 or 8 16-bit words.
// All outputs are decoded from flops only; no input-to-output paths.
module mdom_scdb_hdr_serializer
  import mdom_scdb_hdr_serializer_pkg::*;
#(
  parameter bit         SKIP_BSUM = 1'b1,
  parameter logic [3:0] MAGIC     = MAGIC_DEF
) (
  input logic clk,
  input logic rst,
  mdom_scdb_hdr_serializer_if.slave bus
);

  state_t r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt, w_last_idx;
  logic [BUNDLE_W-1:0] r_hold;
  logic r_hdr_ready;
  logic w_load, w_done;
  logic [15:0] r_hdr_cnt;
  logic [15:0] w_word;
  hdr_t w_hdr;

  mDOM_scdb_hdr_bundle_fan_out u_fan_out (
    .i_bundle(r_hold),
    .o_hdr   (w_hdr)
  );

  // Baseline words are dropped only when the sum is marked invalid
  assign w_last_idx = (SKIP_BSUM && !w_hdr.bsum_valid)
                    ? IDX_W'(WORDS_SHORT - 1)
                    : IDX_W'(WORDS_FULL - 1);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt = r_idx;
    w_load = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.hdr_valid && r_hdr_ready) begin
          w_state_nxt = S_SEND;
          w_idx_nxt = '0;
          w_load = 1'b1;
        end
      end
      S_SEND: begin
        if (bus.dout_ready) begin
          if (r_idx == w_last_idx) begin
            w_state_nxt = S_IDLE;
            w_done = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx <= '0;
      r_hold <= '0;
      r_hdr_ready <= 1'b0;
      r_hdr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx <= w_idx_nxt;
      r_hdr_ready <= (w_state_nxt == S_IDLE);
      if (w_load) r_hold <= bus.hdr_bundle;
      if (w_done) r_hdr_cnt <= r_hdr_cnt + 16'd1;
    end
  end

  always_comb begin
    w_word = '0;
    unique case (r_idx)
      3'd0: w_word = {MAGIC, w_hdr.partial_wfm, w_hdr.continued_wfm,
                      w_hdr.local_coinc, 4'b0, w_hdr.channel_idx};
      3'd1: w_word = w_hdr.evt_ltc[48:33];
      3'd2: w_word = w_hdr.evt_ltc[32:17];
      3'd3: w_word = w_hdr.evt_ltc[16:1];
      3'd4: w_word = {w_hdr.evt_ltc[0], w_hdr.trig_src,
                      w_hdr.cnst_run, w_hdr.start_addr};
      3'd5: w_word = {w_hdr.bsum_len_sel, w_hdr.bsum_valid,
                      w_hdr.stop_addr};
      3'd6: w_word = {w_hdr.pre_conf, w_hdr.sync_rdy, 7'b0,
                      w_hdr.bsum[18:16]};
      3'd7: w_word = w_hdr.bsum[15:0];
    endcase
  end

  assign bus.dout = (r_state == S_SEND) ? w_word : '0;
  assign bus.dout_valid = (r_state == S_SEND);
  assign bus.dout_last = (r_state == S_SEND) && (r_idx == w_last_idx);
  assign bus.hdr_ready = r_hdr_ready;
  assign bus.hdr_cnt = r_hdr_cnt;

endmodule

// File: tb/tb_mdom_scdb_hdr_serializer.sv
// Bench for mdom_scdb_hdr_serializer: random traffic against a
// bit-stream model of the header layout, plus literal pins.
module tb_mdom_scdb_hdr_serializer;
  import mdom_scdb_hdr_serializer_pkg::*;

  typedef logic [15:0] wq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdom_scdb_hdr_serializer_if bus0 ();
  mdom_scdb_hdr_serializer_if bus1 ();

  mdom_scdb_hdr_serializer #(.SKIP_BSUM(1'b1), .MAGIC(4'hA)) u_dut (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  mdom_scdb_hdr_serializer #(.SKIP_BSUM(1'b0), .MAGIC(4'hA)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit rdy_mode = 1'b0;
  bit rst_prev = 1'b1;
  bit stall_prev = 1'b0;
  logic [16:0] prev_out;
  logic [15:0] cnt_m = '0;
  wq_t q0;
  logic [15:0] rx[$];
  logic rx_last[$];
  int rx_cyc[$];
  int acc_cyc[$];
  logic [15:0] rx1[$];
  logic rx1_last[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Header as one 128-bit MSB-first stream, cut into 16-bit words
  function automatic wq_t words(input logic [112:0] b, input bit skip);
    logic [127:0] s;
    int n;
    wq_t q;
    s = {4'hA, b[106], b[107], b[105], 4'b0, b[112:108],
         b[48:1],
         b[0], b[74:73], b[75], b[60:49],
         b[103:101], b[104], b[72:61],
         b[80:76], b[81], 7'b0, b[100:82]};
    n = (skip && !b[104]) ? 6 : 8;
    q = {};
    for (int i = 0; i < n; i++) q.push_back(s[127-16*i -: 16]);
    return q;
  endfunction

  function automatic logic [112:0] rand_bundle();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[112:0];
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_dout", bus0.dout, 0);
      chk("rst_dv", bus0.dout_valid, 0);
      chk("rst_last", bus0.dout_last, 0);
      chk("rst_rdy", bus0.hdr_ready, 0);
      chk("rst_cnt", bus0.hdr_cnt, 0);
      q0.delete();
      cnt_m = '0;
      rst_prev = 1'b1;
      stall_prev = 1'b0;
    end else begin
      chk("dv", bus0.dout_valid, q0.size() != 0);
      chk("rdy", bus0.hdr_ready, !rst_prev && q0.size() == 0);
      chk("cnt", bus0.hdr_cnt, cnt_m);
      chk("last", bus0.dout_last, q0.size() == 1);
      if (q0.size() != 0) chk("dout", bus0.dout, q0[0]);
      if (stall_prev)
        chk("stall_hold", {bus0.dout, bus0.dout_last}, prev_out);
      stall_prev = bus0.dout_valid && !bus0.dout_ready;
      prev_out = {bus0.dout, bus0.dout_last};
      if (q0.size() != 0 && bus0.dout_ready) begin
        rx.push_back(bus0.dout);
        rx_last.push_back(bus0.dout_last);
        rx_cyc.push_back(cyc);
        void'(q0.pop_front());
        if (q0.size() == 0) cnt_m = cnt_m + 16'd1;
      end
      if (bus0.hdr_valid && bus0.hdr_ready) begin
        q0 = words(bus0.hdr_bundle, 1'b1);
        acc_cyc.push_back(cyc);
      end
      rst_prev = 1'b0;
    end
    if (!rst && bus1.dout_valid && bus1.dout_ready) begin
      rx1.push_back(bus1.dout);
      rx1_last.push_back(bus1.dout_last);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    bus0.dout_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send_hdr(input logic [112:0] b);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    bus0.hdr_bundle = b;
    bus0.hdr_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus0.hdr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_timeout", ok, 1);
    @(posedge clk);
    #1;
    bus0.hdr_valid = 1'b0;
    bus0.hdr_bundle = rand_bundle();
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk);
      if (q0.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", ok, 1);
    #2;
  endtask

  logic [112:0] b1, b2, tmp;
  int base, nacc;
  bit ok;
  wq_t exp1;

  initial begin
    bus0.hdr_bundle = '0;
    bus0.hdr_valid = 1'b0;
    bus0.dout_ready = 1'b1;
    bus1.hdr_bundle = '0;
    bus1.hdr_valid = 1'b0;
    bus1.dout_ready = 1'b1;
    b1 = '0;
    b1[48:0] = 49'h1_2345_6789_ABCD;
    b1[112:108] = 5'd17;
    b1[104] = 1'b1;
    b1[100:82] = 19'h5A5A5;
    b2 = b1;
    b2[104] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    base = rx.size();
    send_hdr(b1);
    wait_idle();
    chk("t1_len", rx.size() - base, 8);
    chk("t1_w0", rx[base], 16'hA011);
    chk("t1_w1", rx[base+1], 16'h91A2);
    chk("t1_w3", rx[base+3], 16'hD5E6);
    chk("t1_w6lo", rx[base+6][2:0], 3'b101);
    chk("t1_w7", rx[base+7], 16'hA5A5);
    for (int i = 0; i < 8; i++)
      chk("t1_lastpos", rx_last[base+i], i == 7);
    chk("t1_back2back", rx_cyc[base+7] - rx_cyc[base], 7);
    chk("t1_cnt", bus0.hdr_cnt, 1);

    base = rx.size();
    send_hdr(b2);
    wait_idle();
    chk("t2_len", rx.size() - base, 6);
    chk("t2_last5", rx_last[base+5], 1);
    chk("t2_w5b12", rx[base+5][12], 0);
    chk("t2_cnt", bus0.hdr_cnt, 2);

    @(posedge clk);
    #1;
    bus1.hdr_bundle = b2;
    bus1.hdr_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus1.hdr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("s0_accept", ok, 1);
    @(posedge clk);
    #1 bus1.hdr_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    exp1 = words(b2, 1'b0);
    chk("s0_len", rx1.size(), 8);
    if (rx1.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("s0_word", rx1[i], exp1[i]);
        chk("s0_last", rx1_last[i], i == 7);
      end
      chk("s0_w5b12", rx1[5][12], 0);
      chk("s0_w7", rx1[7], 16'hA5A5);
    end
    chk("s0_cnt", bus1.hdr_cnt, 1);

    base = rx.size();
    send_hdr(b1);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      if (rx.size() >= base + 3) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rst_reach_w3", ok, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_now_dout", bus0.dout, 0);
    chk("rst_now_dv", bus0.dout_valid, 0);
    chk("rst_now_last", bus0.dout_last, 0);
    chk("rst_now_rdy", bus0.hdr_ready, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    base = rx.size();
    send_hdr(b1);
    wait_idle();
    chk("post_rst_w0", rx[base], 16'hA011);
    chk("post_rst_len", rx.size() - base, 8);
    chk("post_rst_cnt", bus0.hdr_cnt, 1);

    rdy_mode = 1'b1;
    base = int'(cnt_m);
    for (int h = 0; h < 100; h++) send_hdr(rand_bundle());
    wait_idle();
    chk("rand_cnt", bus0.hdr_cnt, base + 100);
    chk("rand_cnt_lit", bus0.hdr_cnt, 101);

    rdy_mode = 1'b0;
    @(posedge clk);
    #1;
    nacc = acc_cyc.size();
    bus0.hdr_valid = 1'b1;
    repeat (61) begin
      tmp = rand_bundle();
      tmp[104] = 1'b1;
      bus0.hdr_bundle = tmp;
      @(posedge clk);
      #1;
    end
    bus0.hdr_valid = 1'b0;
    wait_idle();
    chk("cont_accepts", acc_cyc.size() - nacc >= 6, 1);
    for (int i = nacc + 1; i < acc_cyc.size(); i++)
      chk("cont_period", acc_cyc[i] - acc_cyc[i-1], 9);

    @(posedge clk);
    #1;
    force u_dut.r_hdr_cnt = 16'hFFFF;
    #1;
    release u_dut.r_hdr_cnt;
    cnt_m = 16'hFFFF;
    send_hdr(b2);
    wait_idle();
    chk("wrap_cnt", bus0.hdr_cnt, 16'h0000);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
